soc_system_sph_led_sequencer: RTL and testbench

//  Autonomous LED pattern sequencer placed in front of the 10-bit LED PIO.
//  - Avalon-MM slave (s1): HPS/CPU loads a pattern table, step period and mode.
//  - Avalon-MM master (m1): steps through the table, one single-cycle write per step
//    to PIO data register (offset 0). The PIO has no waitrequest.
//  - Frees software from bit-banging blink/chase patterns.

---
 rtl/soc_system_sph_led_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_soc_system_sph_led_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_sph_led_sequencer.sv
// ---------------------------------------------------------------------------
// soc_system_sph_led_sequencer
//
// Autonomous LED pattern sequencer in front of the LED PIO. Software loads a
// pattern table, a step period and a mode through the s1 slave. The sequencer
// then walks the table and issues one single-cycle m1 write per step to the
// PIO data register.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   address[3:0]      s1 word address
//   chipselect        s1 select
//   write_n           s1 write strobe, active low
//   writedata[31:0]   s1 write data
//   readdata[31:0]    s1 read data, combinational from address
//   avm_address[1:0]  m1 address, constant 0 (PIO data register)
//   avm_chipselect    m1 select, high during LOAD
//   avm_write_n       m1 write strobe, low during LOAD
//   avm_writedata     m1 write data, {zeros, pattern[step]}
//   irq               level interrupt, high while DONE with IRQ_EN set
//
// Register map
//   0 CTRL    [0]EN [1]ONESHOT [2]IRQ_EN (any write also clears DONE)
//   1 PERIOD  step interval in clock cycles, 0 behaves as 1
//   2 LENGTH  steps used, stored raw; 0 behaves as 1, >DEPTH as DEPTH
//   3 STATUS  RO [0]RUNNING [1]DONE [6:4]STEP
//   8..8+DEPTH-1 PATTERN[i]
// ---------------------------------------------------------------------------
module soc_system_sph_led_sequencer #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PERIOD_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_ctrl;
  logic [PERIOD_W-1:0]   r_period;
  logic [31:0]           r_length;
  logic [DATA_WIDTH-1:0] r_pattern [8];
  logic [2:0]            r_step;
  logic [2:0]            w_step_nxt;
  logic [PERIOD_W-1:0]   r_cnt;
  logic [PERIOD_W-1:0]   w_cnt_nxt;

  logic                  w_wr;
  logic                  w_wr_ctrl;
  logic                  w_wr_pat;
  logic                  w_en_nxt;
  logic                  w_clr_en;
  logic                  w_decide;
  logic                  w_last;
  logic                  w_load;
  logic                  w_running;
  logic                  w_done;
  logic [PERIOD_W-1:0]   w_period_eff;
  logic [3:0]            w_len_eff;

  // -------------------------------------------------------------------------
  // s1 decode
  // -------------------------------------------------------------------------
  assign w_wr      = chipselect && !write_n;
  assign w_wr_ctrl = w_wr && (address == 4'd0);
  assign w_wr_pat  = w_wr && address[3] && ({1'b0, address[2:0]} < 4'(DEPTH));

  // EN as it will be after this cycle; lets the FSM start in the cycle right
  // after the CTRL write and stop in the cycle right after a clearing write.
  assign w_en_nxt  = w_wr_ctrl ? writedata[0] : r_ctrl[0];

  assign w_period_eff = (r_period == '0) ? P_ONE : r_period;

  always_comb begin
    if (r_length == '0) begin
      w_len_eff = 4'd1;
    end else if (r_length > 32'(DEPTH)) begin
      w_len_eff = 4'(DEPTH);
    end else begin
      w_len_eff = r_length[3:0];
    end
  end

  // ">=" rather than "==" so a LENGTH shrunk below the current step still
  // ends the sequence at this step.
  assign w_last = (({1'b0, r_step} + 4'd1) >= w_len_eff);

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt holds the cycles remaining until the next LOAD, counting the
  // current one; deciding when it reads 1 places LOADs exactly
  // PERIOD_eff cycles apart.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_clr_en    = 1'b0;
    w_decide    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_en_nxt) begin
          w_state_nxt = S_LOAD;
          w_step_nxt  = '0;
        end
      end
      S_LOAD: begin
        w_cnt_nxt = w_period_eff - P_ONE;
        if (!w_en_nxt) begin
          w_state_nxt = S_IDLE;
        end else if (w_period_eff != P_ONE) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_decide = 1'b1;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - P_ONE;
        if (!w_en_nxt) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == P_ONE) begin
          w_decide = 1'b1;
        end
      end
      S_DONE: begin
        if (w_wr_ctrl) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_decide) begin
      if (!w_last) begin
        w_step_nxt  = r_step + 3'd1;
        w_state_nxt = S_LOAD;
      end else if (!r_ctrl[1]) begin
        w_step_nxt  = '0;
        w_state_nxt = S_LOAD;
      end else begin
        w_state_nxt = S_DONE;
        w_clr_en    = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_period <= '0;
      r_length <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_pattern[i] <= '0;
      end
    end else begin
      // A software CTRL write takes precedence over the end-of-oneshot EN clear.
      if (w_wr_ctrl) begin
        r_ctrl <= writedata[2:0];
      end else if (w_clr_en) begin
        r_ctrl[0] <= 1'b0;
      end
      if (w_wr && (address == 4'd1)) begin
        r_period <= writedata[PERIOD_W-1:0];
      end
      if (w_wr && (address == 4'd2)) begin
        r_length <= writedata;
      end
      if (w_wr_pat) begin
        r_pattern[address[2:0]] <= writedata[DATA_WIDTH-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // s1 read path
  // -------------------------------------------------------------------------
  assign w_running = (r_state == S_LOAD) || (r_state == S_WAIT);
  assign w_done    = (r_state == S_DONE);

  always_comb begin
    readdata = '0;
    case (address)
      4'd0: readdata = {29'd0, r_ctrl};
      4'd1: readdata = 32'(r_period);
      4'd2: readdata = r_length;
      4'd3: readdata = {25'd0, r_step, 2'b00, w_done, w_running};
      default: begin
        if (address[3] && ({1'b0, address[2:0]} < 4'(DEPTH))) begin
          readdata = 32'(r_pattern[address[2:0]]);
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // m1 master and interrupt
  // -------------------------------------------------------------------------
  // Gating with reset drops a LOAD strobe in the very cycle reset is raised.
  assign w_load         = (r_state == S_LOAD) && !reset;
  assign avm_address    = '0;
  assign avm_chipselect = w_load;
  assign avm_write_n    = !w_load;
  assign avm_writedata  = w_load ? 32'(r_pattern[r_step]) : '0;
  assign irq            = w_done && r_ctrl[2] && !reset;

endmodule

// File: tb/tb_soc_system_sph_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_soc_system_sph_led_sequencer
//
// Bench for the LED pattern sequencer. A behavioural model tracks the
// register file and a schedule of upcoming PIO writes (absolute cycle of the
// next write, current step) and is checked every cycle. Register map
// vectors, multi-cycle scenarios and a randomized phase drive the DUT.
// ---------------------------------------------------------------------------
module tb_soc_system_sph_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        irq;

  always #5 clk = ~clk;

  soc_system_sph_led_sequencer #(
    .DATA_WIDTH (10),
    .DEPTH      (8),
    .PERIOD_W   (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .irq            (irq)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [31:0] d;
  } load_t;
  load_t loads[$];

  // Reference model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_period;
  logic [31:0] m_length;
  logic [9:0]  m_pat [8];
  bit          m_active;   // a sequence is scheduled or running
  bit          m_started;  // first write of the current run has happened
  bit          m_done;
  int          m_step;
  int          m_next;     // absolute cycle of the next PIO write

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl    = '0;
    m_period  = '0;
    m_length  = '0;
    for (int i = 0; i < 8; i++) m_pat[i] = '0;
    m_active  = 0;
    m_started = 0;
    m_done    = 0;
    m_step    = 0;
    m_next    = 0;
  endtask

  function automatic int peff();
    return (m_period == 0) ? 1 : int'(m_period);
  endfunction

  function automatic int leff();
    if (m_length == 0) return 1;
    if (m_length > 8) return 8;
    return int'(m_length);
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] a, input bit running);
    case (a)
      4'd0:    return {29'd0, m_ctrl};
      4'd1:    return m_period;
      4'd2:    return m_length;
      4'd3:    return {25'd0, 3'(m_step), 2'b00, m_done, running};
      default: return a[3] ? {22'd0, m_pat[a[2:0]]} : 32'd0;
    endcase
  endfunction

  // One clock cycle: drive inputs at the falling edge, check outputs against
  // the model, then advance the model across the following rising edge.
  task automatic cyc1(input bit rst, input bit cs, input bit wn,
                      input logic [3:0] a, input logic [31:0] d);
    bit ld, abort, fin, wr, wr_ctrl, act0, done0, running;
    logic [31:0] exp_wd;
    @(negedge clk);
    reset      = rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    #1;
    if (rst) begin
      check("rst_avm_cs", 32'(avm_chipselect), 32'd0);
      check("rst_avm_wn", 32'(avm_write_n), 32'd1);
      check("rst_irq", 32'(irq), 32'd0);
      m_reset();
      cyc++;
      return;
    end

    ld = m_active && (cyc == m_next);
    if (ld && !m_started) m_step = 0;
    running = m_active && (m_started || ld);
    exp_wd  = ld ? {22'd0, m_pat[m_step[2:0]]} : 32'd0;

    check("avm_cs", 32'(avm_chipselect), 32'(ld));
    check("avm_wn", 32'(avm_write_n), 32'(!ld));
    check("avm_wd", avm_writedata, exp_wd);
    check("avm_addr", 32'(avm_address), 32'd0);
    check("irq", 32'(irq), 32'(m_done && m_ctrl[2]));
    check("readdata", readdata, exp_read(a, running));
    if (avm_chipselect && !avm_write_n) loads.push_back('{cyc, avm_writedata});

    wr      = cs && !wn;
    wr_ctrl = wr && (a == 4'd0);
    act0    = m_active;
    done0   = m_done;
    abort   = wr_ctrl && !d[0] && act0;
    fin     = 0;

    if (ld) begin
      m_started = 1;
      m_next    = cyc + peff();
    end
    if (abort) begin
      m_active = 0;
    end else if (act0 && m_started && (cyc == m_next - 1)) begin
      if (m_step + 1 < leff()) m_step++;
      else if (!m_ctrl[1]) m_step = 0;
      else begin
        m_active = 0;
        fin      = 1;
      end
    end

    if (wr) begin
      case (a)
        4'd0:    m_ctrl   = d[2:0];
        4'd1:    m_period = d;
        4'd2:    m_length = d;
        default: if (a[3]) m_pat[a[2:0]] = d[9:0];
      endcase
    end
    if (fin) begin
      m_done = 1;
      if (!wr_ctrl) m_ctrl[0] = 1'b0;
    end
    if (wr_ctrl && done0) m_done = 0;
    if (wr_ctrl && d[0] && !act0) begin
      m_active  = 1;
      m_started = 0;
      m_next    = cyc + (done0 ? 2 : 1);
    end
    cyc++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc1(0, 1, 0, a, d);
  endtask

  task automatic idle(input logic [3:0] a);
    cyc1(0, 0, 1, a, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] exp2 [5];
  logic [31:0] exp6 [4];
  int          rel6 [4];
  int          c0;
  int          c1;

  initial begin
    m_reset();
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;

    // Reset state
    repeat (3) cyc1(1, 0, 1, 4'd0, 32'd0);
    for (int a = 0; a < 16; a++) begin
      idle(4'(a));
      check("t1_reset_read", readdata, 32'd0);
    end
    check("t1_avm_wn", 32'(avm_write_n), 32'd1);
    check("t1_irq", 32'(irq), 32'd0);

    // Register map vectors: write, then read back the same address
    vecs = '{
      '{4'd1,  32'h1234_5678, 32'h1234_5678},
      '{4'd2,  32'd12,        32'd12},
      '{4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{4'd3,  32'h0000_00FF, 32'h0},
      '{4'd4,  32'h0000_DEAD, 32'h0},
      '{4'd7,  32'h0000_BEEF, 32'h0},
      '{4'd8,  32'hFFFF_FFFF, 32'h3FF},
      '{4'd15, 32'h0000_0155, 32'h155},
      '{4'd0,  32'hFFFF_FFF6, 32'h6},
      '{4'd0,  32'h0,         32'h0},
      '{4'd1,  32'h0,         32'h0},
      '{4'd2,  32'h0,         32'h0}
    };
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].a, vecs[i].d);
      idle(vecs[i].a);
      check("vec_readback", readdata, vecs[i].exp);
    end

    // Looping sequence, period 5
    wr(4'd8, 32'h1); wr(4'd9, 32'h2); wr(4'd10, 32'h4); wr(4'd11, 32'h8);
    wr(4'd2, 32'd4); wr(4'd1, 32'd5);
    loads.delete();
    exp2 = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
    c0 = cyc;
    wr(4'd0, 32'h1);
    repeat (21) idle(4'd3);
    check("t2_nloads", 32'(loads.size()), 32'd5);
    for (int i = 0; i < 5 && i < loads.size(); i++) begin
      check("t2_when", 32'(loads[i].c - c0), 32'(1 + 5 * i));
      check("t2_data", loads[i].d, exp2[i]);
    end
    wr(4'd0, 32'h0);
    repeat (2) idle(4'd3);

    // Oneshot with interrupt
    wr(4'd2, 32'd3); wr(4'd1, 32'd2);
    loads.delete();
    c0 = cyc;
    wr(4'd0, 32'h7);
    repeat (9) idle(4'd3);
    check("t3_status_done", readdata, 32'h22);
    check("t3_irq_high", 32'(irq), 32'd1);
    check("t3_nloads", 32'(loads.size()), 32'd3);
    for (int i = 0; i < 3 && i < loads.size(); i++) begin
      check("t3_data", loads[i].d, 32'(1 << i));
      check("t3_when", 32'(loads[i].c - c0), 32'(1 + 2 * i));
    end
    idle(4'd0);
    check("t3_ctrl_en_cleared", readdata, 32'h6);
    wr(4'd0, 32'h0);
    idle(4'd3);
    check("t3_irq_low", 32'(irq), 32'd0);
    check("t3_status_idle", readdata, 32'h20);

    // PERIOD=0 and LENGTH=0: PATTERN0 every cycle
    wr(4'd8, 32'h3AA); wr(4'd1, 32'd0); wr(4'd2, 32'd0);
    loads.delete();
    c0 = cyc;
    wr(4'd0, 32'h1);
    repeat (6) idle(4'd3);
    check("t4_nloads_p0", 32'(loads.size()), 32'd6);
    for (int i = 0; i < loads.size(); i++) begin
      check("t4_data_p0", loads[i].d, 32'h3AA);
      check("t4_when_p0", 32'(loads[i].c - c0), 32'(i + 1));
    end
    wr(4'd0, 32'h0);

    // LENGTH=12 clamps to 8 steps
    for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'(32'h100 + 3 * i));
    wr(4'd2, 32'd12); wr(4'd1, 32'd1);
    loads.delete();
    wr(4'd0, 32'h1);
    repeat (18) idle(4'd2);
    check("t4_len_raw", readdata, 32'd12);
    check("t4_nloads_len", 32'(loads.size()), 32'd18);
    for (int i = 0; i < loads.size(); i++)
      check("t4_data_wrap", loads[i].d, 32'(32'h100 + 3 * (i % 8)));
    wr(4'd0, 32'h0);
    idle(4'd3);

    // Abort during WAIT of step 2, then restart
    wr(4'd8, 32'h1); wr(4'd9, 32'h2); wr(4'd10, 32'h4); wr(4'd11, 32'h8);
    wr(4'd2, 32'd4); wr(4'd1, 32'd5);
    loads.delete();
    wr(4'd0, 32'h1);
    repeat (12) idle(4'd3);
    wr(4'd0, 32'h0);
    repeat (10) idle(4'd3);
    check("t5_nloads", 32'(loads.size()), 32'd3);
    check("t5_status_abort", readdata, 32'h20);
    c1 = cyc;
    wr(4'd0, 32'h1);
    idle(4'd3);
    check("t5_status_restart", readdata, 32'h01);
    check("t5_restart_data", avm_writedata, 32'h1);
    check("t5_restart_when", 32'(cyc - 1 - c1), 32'd1);
    wr(4'd0, 32'h0);
    idle(4'd3);

    // Live PERIOD and PATTERN updates
    wr(4'd1, 32'd10); wr(4'd2, 32'd4);
    loads.delete();
    exp6 = '{32'h1, 32'h155, 32'h4, 32'h8};
    rel6 = '{1, 11, 14, 17};
    c0 = cyc;
    wr(4'd0, 32'h1);
    idle(4'd3); idle(4'd3);
    wr(4'd1, 32'd3);
    wr(4'd9, 32'h155);
    repeat (14) idle(4'd3);
    check("t6_nloads", 32'(loads.size()), 32'd4);
    for (int i = 0; i < 4 && i < loads.size(); i++) begin
      check("t6_when", 32'(loads[i].c - c0), 32'(rel6[i]));
      check("t6_data", loads[i].d, exp6[i]);
    end
    wr(4'd0, 32'h0);
    idle(4'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [3:0]  a;
      logic [31:0] d;
      r = $urandom_range(0, 499);
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if (r == 0) begin
        cyc1(1, 0, 1, a, 32'd0);
      end else if (r < 125) begin
        if (a == 4'd0) d = $urandom_range(0, 7);
        else if (a == 4'd1) d = $urandom_range(0, 6);
        else if (a == 4'd2) d = $urandom_range(0, 12);
        wr(a, d);
      end else if (r < 150) begin
        cyc1(0, 0, 0, a, d);
      end else begin
        idle(a);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
